// File: rtl/ring_meter_pkg.sv
// Shared types and constants for the ring oscillator frequency meter.
// Holds the measurement FSM encoding and the synchronizer flush length.
package ring_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int SETTLE_CYCLES = 3;

endpackage

// File: rtl/ring_freq_meter_sync.sv
// Brings the selected asynchronous ring output into the clk domain
// and flags a rising edge one cycle wide.
module ring_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ring,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // two-flop synchronizer followed by the edge-history flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= ring;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/ring_freq_meter.sv
// Counts rising edges of one selected ring oscillator over a fixed gate
// window of the system clock and latches the result with a valid strobe.
module ring_freq_meter
    import ring_meter_pkg::*;
#(
    parameter int pRINGS = 4,
    parameter int pSEL_W = 2,
    parameter int pGATE  = 1000,
    parameter int pCNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [pRINGS-1:0] i_ring,
    input  logic [pSEL_W-1:0] i_sel,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_valid,
    output logic [pCNT_W-1:0] o_count,
    output logic              o_ovf
);

    localparam int TMR_W = (pGATE > 1) ? $clog2(pGATE + 1) : 1;
    localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(pGATE - 1);
    localparam logic [1:0]        SETTLE_LAST = 2'(SETTLE_CYCLES - 1);
    localparam logic [pCNT_W-1:0] CNT_MAX     = {pCNT_W{1'b1}};

    state_t                  state_r, state_n;
    logic [pSEL_W-1:0]       sel_r, sel_n;
    logic [TMR_W-1:0]        tmr_r, tmr_n;
    logic [1:0]              stl_r, stl_n;
    logic [pCNT_W-1:0]       cnt_r, cnt_n;
    logic                    sat_r, sat_n;
    logic                    busy_r, valid_r, ovf_r;
    logic [pCNT_W-1:0]       count_r;
    logic [2**pSEL_W-1:0]    ring_pad_s;
    logic                    ring_bit_s;
    logic                    rise_s;

    // pad the ring vector so unpopulated select codes read a constant 0
    always_comb begin
        ring_pad_s             = '0;
        ring_pad_s[pRINGS-1:0] = i_ring;
    end

    assign ring_bit_s = ring_pad_s[sel_r];

    ring_sync_edge u_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .ring  (ring_bit_s),
        .rise  (rise_s)
    );

    // next-state, timers and saturating edge counter
    always_comb begin
        state_n = state_r;
        sel_n   = sel_r;
        tmr_n   = tmr_r;
        stl_n   = stl_r;
        cnt_n   = cnt_r;
        sat_n   = sat_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_n = SETTLE;
                    sel_n   = i_sel;
                    stl_n   = SETTLE_LAST;
                    cnt_n   = '0;
                    sat_n   = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            SETTLE: begin
                if (stl_r == 2'd0) begin
                    state_n = GATE;
                    tmr_n   = GATE_LAST;
                end else begin
                    stl_n = stl_r - 2'd1;
                end
            end
            GATE: begin
                if (rise_s) begin
                    if (cnt_r == CNT_MAX) begin
                        sat_n = 1'b1;
                    end else begin
                        cnt_n = cnt_r + pCNT_W'(1);
                    end
                end else begin
                    cnt_n = cnt_r;
                end
                if (tmr_r == '0) begin
                    state_n = DONE;
                end else begin
                    tmr_n = tmr_r - TMR_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // state, datapath and output registers; results load on entry to DONE
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            sel_r   <= '0;
            tmr_r   <= '0;
            stl_r   <= 2'd0;
            cnt_r   <= '0;
            sat_r   <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            sel_r   <= sel_n;
            tmr_r   <= tmr_n;
            stl_r   <= stl_n;
            cnt_r   <= cnt_n;
            sat_r   <= sat_n;
            busy_r  <= (state_n != IDLE);
            valid_r <= (state_n == DONE);
            if (state_n == DONE) begin
                count_r <= cnt_n;
                ovf_r   <= sat_n;
            end else begin
                count_r <= count_r;
                ovf_r   <= ovf_r;
            end
        end
    end

    assign o_busy  = busy_r;
    assign o_valid = valid_r;
    assign o_count = count_r;
    assign o_ovf   = ovf_r;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: two instances (4 rings/16-bit count and
// 3 rings/3-bit count) share stimulus and are checked against an edge-history model.
module tb_ring_freq_meter;

    localparam int G = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ring;
    logic [1:0]  sel;
    logic        start;

    logic        busy_a, valid_a, ovf_a;
    logic [15:0] count_a;
    logic        busy_b, valid_b, ovf_b;
    logic [2:0]  count_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int per [4];
    int ph  [4];
    logic [3:0] hist [0:29999];
    int last_a = 0;
    int last_b = 0;
    int last_ob = 0;

    always #5 clk = ~clk;

    ring_freq_meter #(.pRINGS(4), .pSEL_W(2), .pGATE(G), .pCNT_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring), .i_sel(sel), .i_start(start),
        .o_busy(busy_a), .o_valid(valid_a), .o_count(count_a), .o_ovf(ovf_a)
    );

    ring_freq_meter #(.pRINGS(3), .pSEL_W(2), .pGATE(G), .pCNT_W(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring[2:0]), .i_sel(sel), .i_start(start),
        .o_busy(busy_b), .o_valid(valid_b), .o_count(count_b), .o_ovf(ovf_b)
    );

    task automatic drive_ring();
        for (int i = 0; i < 4; i++) begin
            if (per[i] == 0) ring[i] = 1'b0;
            else ring[i] = (((cyc + ph[i]) % per[i]) < (per[i] / 2));
        end
        hist[cyc] = ring;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drive_ring();
    endtask

    // rising samples of the chosen ring that land in the gate window
    function automatic int count_rises(input int c0, input int s);
        int n = 0;
        for (int j = c0 + 2; j <= c0 + 1 + G; j++)
            if (hist[j][s] && !hist[j-1][s]) n++;
        return n;
    endfunction

    task automatic run_measure(input int sel_v, input bit hold, input bit disturb,
                               input int ca, input int cb, input int cob, input string tag);
        int c0, nr, ea, eb, eob, busy_bad, valid_bad;
        c0 = cyc;
        sel = sel_v[1:0];
        start = 1'b1;
        busy_bad = 0;
        valid_bad = 0;
        for (int k = 1; k <= G + 4; k++) begin
            tick();
            if (k == 1 && !hold) start = 1'b0;
            if (disturb && k == 50) begin
                sel = ~sel;
                start = 1'b1;
            end
            if (disturb && k == 51) start = 1'b0;
            if (busy_a !== 1'b1 || busy_b !== 1'b1) busy_bad++;
            if (valid_a !== (k == G + 4) || valid_b !== (k == G + 4)) valid_bad++;
            if (k == G + 3) begin
                checks++;
                if (count_a !== 16'(last_a) || count_b !== 3'(last_b) || ovf_b !== last_ob[0]) begin
                    errors++;
                    $display("FAIL %s hold_result: got a=%0d b=%0d ovf_b=%0d want a=%0d b=%0d ovf_b=%0d",
                             tag, count_a, count_b, ovf_b, last_a, last_b, last_ob);
                end
            end
        end
        nr  = count_rises(c0, sel_v);
        ea  = (ca >= 0) ? ca : nr;
        if (cb >= 0) eb = cb;
        else eb = (sel_v >= 3) ? 0 : ((nr > 7) ? 7 : nr);
        if (cob >= 0) eob = cob;
        else eob = (sel_v < 3 && nr > 7) ? 1 : 0;
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy_window: %0d bad cycles, want busy high cycles 1..%0d", tag, busy_bad, G + 4);
        end
        checks++;
        if (valid_bad != 0) begin
            errors++;
            $display("FAIL %s valid_timing: %0d bad cycles, want single strobe at cycle %0d", tag, valid_bad, G + 4);
        end
        checks++;
        if (count_a !== 16'(ea) || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL %s count_a: got %0d ovf %0d want %0d ovf 0", tag, count_a, ovf_a, ea);
        end
        checks++;
        if (count_b !== 3'(eb) || ovf_b !== eob[0]) begin
            errors++;
            $display("FAIL %s count_b: got %0d ovf %0d want %0d ovf %0d", tag, count_b, ovf_b, eb, eob);
        end
        last_a = ea;
        last_b = eb;
        last_ob = eob;
    endtask

    task automatic check_idle(input int n, input string tag);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (busy_a !== 1'b0 || busy_b !== 1'b0 || valid_a !== 1'b0 || valid_b !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s idle: %0d cycles with busy/valid high, want 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if ({busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b} !== 6'b0 || count_a !== 16'd0 || count_b !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: busy %0d/%0d valid %0d/%0d count %0d/%0d ovf %0d/%0d want all 0",
                     busy_a, busy_b, valid_a, valid_b, count_a, count_b, ovf_a, ovf_b);
        end
        rst_n = 1'b1;
        check_idle(10, "reset_quiet");
    endtask

    task automatic test_basic();
        per[0] = 0; per[1] = 10; per[2] = 0; per[3] = 0;
        run_measure(1, 1'b0, 1'b0, 10, 7, 1, "basic_p10");
        check_idle(2, "basic_p10");
    endtask

    task automatic test_saturation();
        per[0] = 4;
        run_measure(0, 1'b0, 1'b0, 25, 7, 1, "sat_p4");
        check_idle(1, "sat_p4");
        per[0] = 50;
        run_measure(0, 1'b0, 1'b0, 2, 2, 0, "sat_p50");
        check_idle(1, "sat_p50");
    endtask

    task automatic test_select();
        per[2] = 0; per[3] = 10;
        run_measure(2, 1'b0, 1'b0, 0, 0, 0, "sel_quiet");
        check_idle(1, "sel_quiet");
        run_measure(3, 1'b0, 1'b0, 10, 0, 0, "sel_unpop");
        check_idle(1, "sel_unpop");
    endtask

    task automatic test_mid_change();
        per[1] = 8; per[2] = 20;
        run_measure(1, 1'b0, 1'b1, -1, -1, -1, "mid_change");
        check_idle(6, "mid_change");
    endtask

    task automatic test_back_to_back();
        per[0] = 6;
        run_measure(0, 1'b1, 1'b0, -1, -1, -1, "b2b_first");
        check_idle(1, "b2b_gap");
        run_measure(0, 1'b0, 1'b0, -1, -1, -1, "b2b_second");
        check_idle(1, "b2b_second");
    endtask

    task automatic test_reset_abort();
        int bad = 0;
        per[1] = 5;
        sel = 2'd1;
        start = 1'b1;
        for (int k = 1; k <= 54; k++) begin
            tick();
            if (k == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (valid_a !== 1'b0 || valid_b !== 1'b0 || busy_a !== 1'b0 || count_a !== 16'd0 || count_b !== 3'd0 || ovf_b !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_reset: %0d cycles with nonzero outputs after abort, want 0", bad);
        end
        last_a = 0; last_b = 0; last_ob = 0;
        run_measure(1, 1'b0, 1'b0, 20, 7, 1, "abort_restart");
        check_idle(1, "abort_restart");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                per[i] = $urandom_range(3, 40);
                ph[i]  = $urandom_range(0, 39);
            end
            run_measure($urandom_range(0, 3), 1'b0, 1'b0, -1, -1, -1, "random");
            check_idle($urandom_range(1, 4), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            per[i] = 0;
            ph[i]  = 0;
        end
        sel = 2'd0;
        start = 1'b0;
        rst_n = 1'b0;
        drive_ring();
        test_reset();
        test_basic();
        test_saturation();
        test_select();
        test_mid_change();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_freq_meter.md
# ring_freq_meter

Measures the frequency of one of the on-die ring-oscillator clocks against the system clock, which may be the tile clock or a scan clock. A selected ring output is synchronized into the system clock domain and its rising edges are counted over a fixed gate window. The result is presented as a latched count with a one-cycle valid strobe. The block is the receiving end of the ring oscillator outputs and sits in the top beside the ring instances, which now drive it instead of going straight to pins.

## Interface
- pRINGS, 4: number of ring inputs.
- pSEL_W, 2: select width; must satisfy 2^pSEL_W >= pRINGS.
- pGATE, 1000: gate window length in i_clk cycles; must be >= 1.
- pCNT_W, 16: count width.
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  synchronous, active-low reset, sampled on i_clk.
- i_ring  in  pRINGS  asynchronous ring oscillator outputs.
- i_sel  in  pSEL_W  ring index; values >= pRINGS select constant 0.
- i_start  in  1  measurement request, level-sampled.
- o_busy  out  1  measurement in progress.
- o_valid  out  1  one-cycle strobe when o_count updates.
- o_count  out  pCNT_W  edge count from the last completed measurement.
- o_ovf  out  1  last measurement saturated.

## Operation
- Input path:
  - Selected ring bit = i_ring[sel_q], where sel_q is the select register.
  - The selected bit passes through a 2-flop synchronizer, then a third flop.
  - Rising edge = s2 & ~s3.
- The synchronizer and edge flops reset to 0.
- FSM states: IDLE, SETTLE, GATE, DONE.
  - IDLE: if i_start=1, capture i_sel into sel_q, clear the counter, and go to SETTLE. Otherwise stay in IDLE.
  - SETTLE: run exactly 3 cycles to flush the synchronizer after a select change. Edges are not counted. Then go to GATE.
  - GATE: run exactly pGATE cycles. Each cycle with a rising edge increments the counter. Then go to DONE.
  - DONE: 1 cycle. Load o_count from the counter, load o_ovf from the saturation flag, pulse o_valid, and go to IDLE.
- i_start is ignored outside IDLE.
- i_sel changes after capture have no effect until the next start.
- If i_start is held high, back-to-back measurements run with one IDLE cycle between them.
- Counter arithmetic:
  - pCNT_W bits, unsigned, saturating at 2^pCNT_W-1.
  - An edge arriving at saturation sets the sticky overflow flag for the current measurement.
  - The counter and the flag clear on entry to SETTLE.
- o_count and o_ovf hold their values between measurements and change only in DONE.
- Input frequency must be below i_clk/2. Faster inputs alias; that range is undefined and not checked.
- Reset values: state=IDLE, o_busy=0, o_valid=0, o_count=0, o_ovf=0, sel_q=0, counters=0.
- Reset mid-measurement aborts with no o_valid pulse, and all outputs return to their reset values.

## Timing
- Call the cycle where i_start is sampled high in IDLE cycle 0.
- SETTLE occupies cycles 1–3. GATE occupies cycles 4 through 3+pGATE. DONE is cycle 4+pGATE.
- o_busy = (state != IDLE): high in cycles 1 through 4+pGATE.
- o_valid is high only in cycle 4+pGATE. o_count and o_ovf take their new values in that same cycle.
- Start-to-valid latency is pGATE+4 cycles.
- Edge attribution:
  - A ring rise is detected 3–4 cycles after it occurs.
  - The count covers detections in GATE cycles only.
  - A detection in the last SETTLE cycle is excluded. A detection in the last GATE cycle is included.
- Earliest restart: i_start sampled in the IDLE cycle at 5+pGATE.

## Structure
- Package ring_meter_pkg holds:
  - the state enum (IDLE, SETTLE, GATE, DONE);
  - localparam SETTLE_CYCLES = 3.
- Sub-module ring_sync_edge holds the 2-flop synchronizer, the edge flop and the rise output. The same synchronous active-low reset applies.
- The top mux, FSM, gate timer (width clog2(pGATE+1)) and saturating counter live in ring_freq_meter.
- In the chip top, the ring o_clk outputs feed i_ring.

## Test plan
1. Reset: hold i_rst_n=0 for 5 cycles → o_busy=0, o_valid=0, o_count=0, o_ovf=0; no activity until i_start.
2. Setup pGATE=100, pCNT_W=16. Drive i_ring[1] with period 10 cycles (50% duty), i_sel=1, pulse i_start → o_valid exactly 104 cycles later, o_count=10, o_ovf=0, and o_busy high for 104 cycles.
3. Setup pCNT_W=3, pGATE=100. Drive i_ring[0] with period 4 cycles → o_count=7, o_ovf=1. A following run at period 50 cycles → o_count=2, o_ovf=0.
4. Hold i_ring[2]=0 with i_sel=2 → o_count=0. Set i_sel=3 with pRINGS=3 while ring 3 toggles → o_count=0.
5. Change i_sel and pulse i_start mid-measurement → result reflects the original ring; the extra start is ignored; one o_valid pulse.
6. Assert i_rst_n=0 at cycle 50 of GATE → no o_valid, o_count stays 0. A restart after reset produces a correct count.
